// File: rtl/ysyx_25030093_ifu.sv
// Instruction fetch unit: turns each new PC into a single-beat AR/R read and
// hands the fetched instruction to decode over a valid/ready handshake.
module ysyx_25030093_ifu #(
  parameter logic [31:0] RESET_INST  = 32'h0000_0013,
  parameter int unsigned FETCH_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            pc,
  input  logic                   pc_valid,
  output logic                   arvalid,
  output logic [31:0]            araddr,
  input  logic                   arready,
  input  logic                   rvalid,
  input  logic [31:0]            rdata,
  input  logic [1:0]             rresp,
  output logic                   rready,
  output logic [31:0]            inst,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic                   fetch_fault,
  output logic                   busy,
  output logic [FETCH_CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [31:0]            araddr_d;
  logic [31:0]            inst_d;
  logic                   fault_d;
  logic [FETCH_CNT_W-1:0] cnt_d;

  logic pc_aligned;
  assign pc_aligned = (pc[1:0] == 2'b00);

  // State and registered outputs; handshake flags are decoded from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      arvalid     <= 1'b0;
      araddr      <= '0;
      rready      <= 1'b0;
      inst        <= RESET_INST;
      inst_valid  <= 1'b0;
      fetch_fault <= 1'b0;
      busy        <= 1'b0;
      fetch_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      arvalid     <= (state_d == S_AR);
      araddr      <= araddr_d;
      rready      <= (state_d == S_R);
      inst        <= inst_d;
      inst_valid  <= (state_d == S_OUT);
      fetch_fault <= fault_d;
      busy        <= (state_d != S_IDLE);
      fetch_cnt   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (pc_valid)               state_d = pc_aligned ? S_AR : S_OUT;
      S_AR:   if (arvalid && arready)     state_d = S_R;
      S_R:    if (rready && rvalid)       state_d = S_OUT;
      S_OUT:  if (inst_valid && inst_ready) state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  // Datapath next values; a misaligned PC skips the bus and faults directly.
  always_comb begin
    araddr_d = araddr;
    inst_d   = inst;
    fault_d  = fetch_fault;
    cnt_d    = fetch_cnt;
    unique case (state_q)
      S_IDLE: begin
        if (pc_valid) begin
          if (pc_aligned) begin
            araddr_d = pc;
          end else begin
            inst_d  = 32'h0000_0000;
            fault_d = 1'b1;
          end
        end
      end
      S_R: begin
        if (rready && rvalid) begin
          inst_d  = rdata;
          fault_d = (rresp != 2'b00);
        end
      end
      S_OUT: begin
        if (inst_valid && inst_ready) begin
          cnt_d   = fetch_cnt + FETCH_CNT_W'(1);
          inst_d  = RESET_INST;
          fault_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25030093_ifu.sv
// Directed bench for the fetch unit with a 2-bit fetch counter so wrap is visible.
module tb_ysyx_25030093_ifu;

  localparam int unsigned CW = 2;

  logic          clk;
  logic          rst;
  logic [31:0]   pc;
  logic          pc_valid;
  logic          arvalid;
  logic [31:0]   araddr;
  logic          arready;
  logic          rvalid;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rready;
  logic [31:0]   inst;
  logic          inst_valid;
  logic          inst_ready;
  logic          fetch_fault;
  logic          busy;
  logic [CW-1:0] fetch_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CW-1:0] exp_cnt;

  ysyx_25030093_ifu #(
    .RESET_INST (32'h0000_0013),
    .FETCH_CNT_W(CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .arvalid    (arvalid),
    .araddr     (araddr),
    .arready    (arready),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .rresp      (rresp),
    .rready     (rready),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .fetch_fault(fetch_fault),
    .busy       (busy),
    .fetch_cnt  (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are then observed 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_valid   = 1'b0;
    arready    = 1'b0;
    rvalid     = 1'b0;
    rresp      = 2'b00;
    inst_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    pc = 32'h0; rdata = 32'h0;
    rst = 1'b1;
    step(); step();
    n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %b expected 0", arvalid); end
    n_checks++; if (araddr !== 32'h0) begin n_fail++; $display("FAIL reset_araddr: got %h expected 00000000", araddr); end
    n_checks++; if (rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready: got %b expected 0", rready); end
    n_checks++; if (inst !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_inst: got %h expected 00000013", inst); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
    n_checks++; if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", fetch_fault); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (fetch_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", fetch_cnt); end
    rst = 1'b0;
    exp_cnt = '0;
    step();
  endtask

  task automatic test_basic();
    pc = 32'h8000_0000; pc_valid = 1'b1;
    arready = 1'b1; rvalid = 1'b1; rdata = 32'h0010_0093; rresp = 2'b00; inst_ready = 1'b1;
    step();
    pc_valid = 1'b0;
    n_checks++; if (arvalid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_c1_arvalid: got arvalid=%b busy=%b expected 1 1", arvalid, busy); end
    n_checks++; if (araddr !== 32'h8000_0000) begin n_fail++; $display("FAIL basic_c1_araddr: got %h expected 80000000", araddr); end
    step();
    n_checks++; if (rready !== 1'b1 || arvalid !== 1'b0) begin n_fail++; $display("FAIL basic_c2_rready: got rready=%b arvalid=%b expected 1 0", rready, arvalid); end
    step();
    n_checks++; if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || fetch_fault !== 1'b0) begin n_fail++; $display("FAIL basic_c3_out: got valid=%b inst=%h fault=%b expected 1 00100093 0", inst_valid, inst, fetch_fault); end
    step();
    exp_cnt = exp_cnt + 2'd1;
    n_checks++; if (inst_valid !== 1'b0 || busy !== 1'b0 || inst !== 32'h0000_0013) begin n_fail++; $display("FAIL basic_c4_idle: got valid=%b busy=%b inst=%h expected 0 0 00000013", inst_valid, busy, inst); end
    n_checks++; if (fetch_cnt !== exp_cnt) begin n_fail++; $display("FAIL basic_cnt: got %0d expected %0d", fetch_cnt, exp_cnt); end
    idle_inputs();
  endtask

  task automatic test_wait_states();
    pc = 32'h8000_0004; pc_valid = 1'b1;
    step();
    pc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0004) begin n_fail++; $display("FAIL wait_ar_hold%0d: got arvalid=%b araddr=%h expected 1 80000004", i, arvalid, araddr); end
      step();
    end
    arready = 1'b1;
    n_checks++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0004) begin n_fail++; $display("FAIL wait_ar_hs: got arvalid=%b araddr=%h expected 1 80000004", arvalid, araddr); end
    step();
    arready = 1'b0;
    // A stray pc_valid outside IDLE must not disturb the transaction.
    pc = 32'h1234_5670; pc_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (rready !== 1'b1 || arvalid !== 1'b0) begin n_fail++; $display("FAIL wait_r_hold%0d: got rready=%b arvalid=%b expected 1 0", i, rready, arvalid); end
      step();
    end
    pc_valid = 1'b0; pc = 32'h8000_0004;
    rvalid = 1'b1; rdata = 32'h0020_0113;
    step();
    rvalid = 1'b0; rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (inst_valid !== 1'b1 || inst !== 32'h0020_0113 || araddr !== 32'h8000_0004) begin n_fail++; $display("FAIL wait_out_hold%0d: got valid=%b inst=%h araddr=%h expected 1 00200113 80000004", i, inst_valid, inst, araddr); end
      step();
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    exp_cnt = exp_cnt + 2'd1;
    n_checks++; if (inst_valid !== 1'b0 || busy !== 1'b0 || fetch_cnt !== exp_cnt) begin n_fail++; $display("FAIL wait_done: got valid=%b busy=%b cnt=%0d expected 0 0 %0d", inst_valid, busy, fetch_cnt, exp_cnt); end
  endtask

  task automatic test_misaligned();
    pc = 32'h8000_0002; pc_valid = 1'b1; arready = 1'b1;
    step();
    pc_valid = 1'b0;
    n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL mis_no_ar: got arvalid=%b expected 0", arvalid); end
    n_checks++; if (inst_valid !== 1'b1 || fetch_fault !== 1'b1 || inst !== 32'h0) begin n_fail++; $display("FAIL mis_out: got valid=%b fault=%b inst=%h expected 1 1 00000000", inst_valid, fetch_fault, inst); end
    inst_ready = 1'b1;
    step();
    exp_cnt = exp_cnt + 2'd1;
    n_checks++; if (arvalid !== 1'b0 || inst_valid !== 1'b0 || fetch_fault !== 1'b0 || fetch_cnt !== exp_cnt) begin n_fail++; $display("FAIL mis_done: got arvalid=%b valid=%b fault=%b cnt=%0d expected 0 0 0 %0d", arvalid, inst_valid, fetch_fault, fetch_cnt, exp_cnt); end
    idle_inputs();
  endtask

  task automatic test_bus_error();
    pc = 32'h8000_0008; pc_valid = 1'b1;
    arready = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b10; inst_ready = 1'b1;
    step(); pc_valid = 1'b0;
    step(); step();
    n_checks++; if (inst_valid !== 1'b1 || inst !== 32'hDEAD_BEEF || fetch_fault !== 1'b1) begin n_fail++; $display("FAIL buserr_out: got valid=%b inst=%h fault=%b expected 1 deadbeef 1", inst_valid, inst, fetch_fault); end
    step();
    exp_cnt = exp_cnt + 2'd1;
    n_checks++; if (fetch_cnt !== exp_cnt) begin n_fail++; $display("FAIL buserr_cnt: got %0d expected %0d", fetch_cnt, exp_cnt); end
    pc = 32'h8000_000C; pc_valid = 1'b1; rdata = 32'h0030_0193; rresp = 2'b00;
    step(); pc_valid = 1'b0;
    step(); step();
    n_checks++; if (inst_valid !== 1'b1 || inst !== 32'h0030_0193 || fetch_fault !== 1'b0) begin n_fail++; $display("FAIL okay_after_err: got valid=%b inst=%h fault=%b expected 1 00300193 0", inst_valid, inst, fetch_fault); end
    step();
    exp_cnt = exp_cnt + 2'd1;
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    pc = 32'h8000_0010; pc_valid = 1'b1; arready = 1'b1;
    step(); pc_valid = 1'b0;
    step();
    n_checks++; if (rready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_r: got rready=%b expected 1", rready); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = '0;
    n_checks++; if (rready !== 1'b0 || arvalid !== 1'b0 || inst_valid !== 1'b0 || busy !== 1'b0 || fetch_cnt !== 2'd0) begin n_fail++; $display("FAIL rstmid_idle: got rready=%b arvalid=%b valid=%b busy=%b cnt=%0d expected 0 0 0 0 0", rready, arvalid, inst_valid, busy, fetch_cnt); end
    rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
    step();
    rvalid = 1'b0;
    n_checks++; if (inst_valid !== 1'b0 || busy !== 1'b0 || inst !== 32'h0000_0013) begin n_fail++; $display("FAIL rstmid_stale_rvalid: got valid=%b busy=%b inst=%h expected 0 0 00000013", inst_valid, busy, inst); end
    pc = 32'h8000_0014; pc_valid = 1'b1; rvalid = 1'b1; rdata = 32'h0040_0213; inst_ready = 1'b1;
    step(); pc_valid = 1'b0;
    n_checks++; if (araddr !== 32'h8000_0014 || arvalid !== 1'b1) begin n_fail++; $display("FAIL rstmid_refetch_ar: got araddr=%h arvalid=%b expected 80000014 1", araddr, arvalid); end
    step(); step();
    n_checks++; if (inst_valid !== 1'b1 || inst !== 32'h0040_0213) begin n_fail++; $display("FAIL rstmid_refetch_out: got valid=%b inst=%h expected 1 00400213", inst_valid, inst); end
    step();
    exp_cnt = exp_cnt + 2'd1;
    n_checks++; if (fetch_cnt !== exp_cnt) begin n_fail++; $display("FAIL rstmid_cnt: got %0d expected %0d", fetch_cnt, exp_cnt); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_inst;
    rst = 1'b1; step(); rst = 1'b0;
    exp_cnt = '0;
    // pc_valid held high: only IDLE may accept it, giving one fetch per 4 cycles.
    pc_valid = 1'b1; arready = 1'b1; rvalid = 1'b1; rresp = 2'b00; inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (busy !== 1'b0 || fetch_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b_idle%0d: got busy=%b cnt=%0d expected 0 %0d", i, busy, fetch_cnt, exp_cnt); end
      pc = 32'h8000_0100 + 32'(i * 4);
      exp_inst = 32'h0000_0093 + 32'(i << 20);
      rdata = exp_inst;
      step();
      n_checks++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0100 + 32'(i * 4)) begin n_fail++; $display("FAIL b2b_ar%0d: got arvalid=%b araddr=%h", i, arvalid, araddr); end
      step();
      n_checks++; if (rready !== 1'b1 || arvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_r%0d: got rready=%b arvalid=%b expected 1 0", i, rready, arvalid); end
      step();
      n_checks++; if (inst_valid !== 1'b1 || inst !== exp_inst) begin n_fail++; $display("FAIL b2b_out%0d: got valid=%b inst=%h expected 1 %h", i, inst_valid, inst, exp_inst); end
      step();
      exp_cnt = exp_cnt + 2'd1;
    end
    pc_valid = 1'b0;
    n_checks++; if (busy !== 1'b0 || fetch_cnt !== 2'd0) begin n_fail++; $display("FAIL b2b_wrap: got busy=%b cnt=%0d expected 0 0", busy, fetch_cnt); end
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_misaligned();
    test_bus_error();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
